// File: rtl/debug_tx_sequencer.sv
// Debug-unit transmit sequencer: snapshots PC/cycle count, walks the register file and
// serializes a byte frame into the UART TX FIFO. Optional XOR checksum via DEBUG_TX_CHECKSUM_EN.
module debug_tx_sequencer #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        global_reset,
   input  logic        send_data,
   input  logic        tx_full,
   input  logic [31:0] pc,
   input  logic [31:0] cycle_count,
   input  logic [31:0] reg_data,
   output logic [4:0]  reg_sel,
   output logic        wr_uart,
   output logic [7:0]  w_data,
   output logic        data_sent
);

   localparam logic [7:0] HEADER   = 8'hA5;
   localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PC,
      S_CNT,
      S_LOAD,
      S_REG,
`ifdef DEBUG_TX_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t      state, next_state;
   logic        send_q;
   logic [31:0] pc_snap, cnt_snap, shift_reg;
   logic [4:0]  reg_idx;
   logic [1:0]  byte_ptr;
   logic        accept, emit, can_write, last_byte;
   logic [7:0]  cur_byte;
`ifdef DEBUG_TX_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] ptr);
      case (ptr)
         2'd0:    byte_of = word[31:24];
         2'd1:    byte_of = word[23:16];
         2'd2:    byte_of = word[15:8];
         default: byte_of = word[7:0];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (global_reset) state <= S_IDLE;
      else              state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      emit       = 1'b0;
      cur_byte   = 8'h00;
      data_sent  = 1'b0;
      // Reset gates the strobe so an aborted frame writes nothing on the reset edge.
      can_write  = !tx_full && !global_reset;
      last_byte  = (byte_ptr == 2'd3);
      case (state)
         S_IDLE: begin
            if (send_data && !send_q) begin
               accept     = 1'b1;
               next_state = S_HDR;
            end
         end
         S_HDR: begin
            emit     = 1'b1;
            cur_byte = HEADER;
            if (can_write) next_state = S_PC;
         end
         S_PC: begin
            emit     = 1'b1;
            cur_byte = byte_of(pc_snap, byte_ptr);
            if (can_write && last_byte) next_state = S_CNT;
         end
         S_CNT: begin
            emit     = 1'b1;
            cur_byte = byte_of(cnt_snap, byte_ptr);
            if (can_write && last_byte) next_state = S_LOAD;
         end
         S_LOAD: next_state = S_REG;
         S_REG: begin
            emit     = 1'b1;
            cur_byte = shift_reg[31:24];
            if (can_write && last_byte) begin
               if (reg_idx != LAST_REG) next_state = S_LOAD;
`ifdef DEBUG_TX_CHECKSUM_EN
               else                     next_state = S_CSUM;
`else
               else                     next_state = S_DONE;
`endif
            end
         end
`ifdef DEBUG_TX_CHECKSUM_EN
         S_CSUM: begin
            emit     = 1'b1;
            cur_byte = csum;
            if (can_write) next_state = S_DONE;
         end
`endif
         S_DONE: begin
            data_sent  = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      wr_uart = emit && can_write;
      w_data  = cur_byte;
   end

   always_ff @(posedge clk) begin
      if (global_reset) begin
         send_q   <= 1'b0;
         pc_snap  <= '0;
         cnt_snap <= '0;
         reg_idx  <= '0;
         byte_ptr <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
         csum     <= '0;
`endif
      end else begin
         send_q <= send_data;
         if (accept) begin
            pc_snap  <= pc;
            cnt_snap <= cycle_count;
            reg_idx  <= '0;
            byte_ptr <= '0;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (wr_uart) begin
            // The 2-bit pointer wraps to 0 at the end of each word, ready for the next one.
            if (state == S_PC || state == S_CNT || state == S_REG) byte_ptr <= byte_ptr + 2'd1;
`ifdef DEBUG_TX_CHECKSUM_EN
            csum <= csum ^ w_data;
`endif
            if (state == S_REG && last_byte && reg_idx != LAST_REG) reg_idx <= reg_idx + 5'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_LOAD)                shift_reg <= reg_data;
      else if (wr_uart && state == S_REG) shift_reg <= {shift_reg[23:0], 8'h00};
   end

   assign reg_sel = reg_idx;

endmodule
